// File: rtl/sound_gen_pkg.sv
// Shared register map, CTRL layout, noise LFSR definition and envelope step size
// for the multi-channel sound generator.
package sound_gen_pkg;

  localparam logic [1:0] REG_FREQ_LO = 2'd0;
  localparam logic [1:0] REG_FREQ_HI = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_ENV     = 2'd3;

  localparam int CTRL_EN      = 7;
  localparam int CTRL_MODE    = 6;
  localparam int CTRL_ONESHOT = 5;

  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;  // x^15 + x^14 + 1, right-shifting Galois

  localparam int DECAY_STEP = 4096;

  typedef struct packed {
    logic en;
    logic mode;
    logic oneshot;
  } ctrl_t;

  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    logic [14:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    if (n == 15'h0000) n = LFSR_SEED;
    return n;
  endfunction

endpackage

// File: rtl/sound_channel.sv
// One tone/noise voice: period counter, phase, noise LFSR, decaying volume and one-shot stop.
// Register writes land on the clk edge with we=1; amp and rd_dat are combinational from state.
module sound_channel
  import sound_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] data_in,
  output logic [7:0] rd_dat,
  output logic [3:0] amp
);

  logic [7:0]  freq_lo;
  logic [15:0] period;
  ctrl_t       ctrl;
  logic [3:0]  rate;
  logic [3:0]  vol;
  logic [15:0] cnt;
  logic        phase;
  logic [14:0] lfsr;
  logic [15:0] decay_cnt;

  logic        wr_lo, wr_hi, wr_ctrl, wr_env, en_rise, tone;
  logic [15:0] decay_lim;

  assign wr_lo     = we && (reg_sel == REG_FREQ_LO);
  assign wr_hi     = we && (reg_sel == REG_FREQ_HI);
  assign wr_ctrl   = we && (reg_sel == REG_CTRL);
  assign wr_env    = we && (reg_sel == REG_ENV);
  assign en_rise   = wr_ctrl && data_in[CTRL_EN] && !ctrl.en;
  assign decay_lim = ({rate, 12'h000}) - 16'd1;  // rate * DECAY_STEP - 1

  always_ff @(posedge clk) begin
    if (!reset) begin
      freq_lo   <= '0;
      period    <= '0;
      ctrl      <= '0;
      rate      <= '0;
      vol       <= '0;
      cnt       <= '0;
      phase     <= 1'b0;
      lfsr      <= LFSR_SEED;
      decay_cnt <= '0;
    end else begin
      if (wr_lo) freq_lo <= data_in;
      if (wr_hi) period <= {data_in, freq_lo};

      if (wr_ctrl)
        ctrl <= ctrl_t'(data_in[7:5]);
      else if (ctrl.en && ctrl.oneshot && (vol == 4'd0))
        ctrl.en <= 1'b0;

      // A CPU write beats a coincident decay step and restarts the decay interval.
      if (wr_env) begin
        rate      <= data_in[7:4];
        vol       <= data_in[3:0];
        decay_cnt <= '0;
      end else if (tick && (rate != 4'd0)) begin
        if (decay_cnt == decay_lim) begin
          decay_cnt <= '0;
          if (vol != 4'd0) vol <= vol - 4'd1;
        end else begin
          decay_cnt <= decay_cnt + 16'd1;
        end
      end

      if (en_rise) begin
        cnt   <= period;
        phase <= 1'b0;
      end else if (ctrl.en && tick) begin
        if (period == 16'd0) begin
          cnt <= '0;
        end else if (cnt == 16'd0) begin
          cnt   <= period;
          phase <= ~phase;
          if (ctrl.mode) lfsr <= lfsr_next(lfsr);
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

  assign tone = ctrl.mode ? lfsr[0] : phase;
  assign amp  = (ctrl.en && (period != 16'd0) && tone) ? vol : 4'd0;

  always_comb begin
    rd_dat = '0;
    case (reg_sel)
      REG_FREQ_LO: rd_dat = freq_lo;
      REG_FREQ_HI: rd_dat = period[15:8];
      REG_CTRL:    rd_dat = {ctrl, 5'b00000};
      default:     rd_dat = {rate, vol};
    endcase
  end

endmodule

// File: rtl/sound_gen_io.sv
// I/O-bus sound generator: NCH voices mixed and sent out as a first-order sigma-delta bit stream.
// Two clk from a channel amplitude change to signal_out (mixer register, accumulator); no bus stalls.
module sound_gen_io
  import sound_gen_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PRESCALE = 4,
  parameter int ADDR_W   = $clog2(NCH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  input  logic              re,
  input  logic              we,
  output logic              signal_out
);

  localparam int SUM_W = 4 + $clog2(NCH);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic [ADDR_W-1:0] ch_idx;
  logic [3:0]        amp    [NCH];
  logic [7:0]        rd_dat [NCH];
  logic [SUM_W-1:0]  sum_nxt, sum_q;
  logic [SUM_W:0]    acc;

  assign tick   = (pre == PRE_W'(PRESCALE - 1));
  assign ch_idx = addr >> 2;

  always_ff @(posedge clk) begin
    if (!reset)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PRE_W'(1);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sound_channel u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .we      (we && (ch_idx == ADDR_W'(i))),
      .reg_sel (addr[1:0]),
      .data_in (data_in),
      .rd_dat  (rd_dat[i]),
      .amp     (amp[i])
    );
  end

  // Channel indices at or above NCH match no voice, so they read as zero.
  always_comb begin
    data_out = '0;
    if (re) begin
      for (int i = 0; i < NCH; i++)
        if (ch_idx == ADDR_W'(i)) data_out = rd_dat[i];
    end
  end

  always_comb begin
    sum_nxt = '0;
    for (int i = 0; i < NCH; i++) sum_nxt = sum_nxt + SUM_W'(amp[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
      acc   <= '0;
    end else begin
      sum_q <= sum_nxt;
      acc   <= {1'b0, acc[SUM_W-1:0]} + {1'b0, sum_q};
    end
  end

  // The accumulator carry is the output bit; its density equals sum / 2^SUM_W.
  assign signal_out = acc[SUM_W];

endmodule

// File: tb/tb_sound_gen_io.sv
// Self-checking bench for sound_gen_io: register model, tone timing/density, decay, noise, bus corners.
module tb_sound_gen_io;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    data_in = '0;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [7:0]    data_out, data_out3;
  logic          signal_out, signal_out3;

  int n_chk = 0;
  int n_pass = 0;
  int since_rst = 0;

  always #5 clk = ~clk;
  always @(posedge clk) since_rst <= reset ? since_rst + 1 : 0;

  sound_gen_io #(.NCH(4), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out),
    .re(re), .we(we), .signal_out(signal_out));

  sound_gen_io #(.NCH(3), .PRESCALE(4)) dut3 (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out3),
    .re(re), .we(we), .signal_out(signal_out3));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint near(input longint obs, input longint exp, input longint tol);
    return (obs >= exp - tol && obs <= exp + tol) ? exp : obs;
  endfunction

  function automatic logic [14:0] ref_lfsr(input logic [14:0] s);
    logic [14:0] n;
    n = (s >> 1) ^ (s[0] ? 15'h6000 : 15'h0000);
    return (n == 15'h0) ? 15'h0001 : n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    addr = AW'(a); data_in = 8'(d); we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input int a, output int v, output int v3);
    addr = AW'(a); re = 1'b1;
    #1;
    v = int'(data_out); v3 = int'(data_out3);
    re = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (since_rst < t) @(negedge clk);
  endtask

  task automatic align(input int r);
    while (since_rst % 4 != r) @(negedge clk);
  endtask

  // A rise is the first 1 after at least 12 consecutive zeros (phase went high).
  task automatic next_rise(output int t);
    int zeros = 0;
    t = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (signal_out) begin
        if (zeros >= 12) begin t = since_rst; return; end
        zeros = 0;
      end else zeros++;
    end
  endtask

  task automatic meas_period(output int p);
    int a, b;
    next_rise(a);
    next_rise(b);
    p = (a < 0 || b < 0) ? -1 : b - a;
  endtask

  task automatic count_ones(input int n, output int c);
    c = 0;
    repeat (n) begin @(negedge clk); c += int'(signal_out); end
  endtask

  // Square tone: full period 2*(p+1) ticks = 8*(p+1) clk; density over 10 periods is v/128.
  task automatic tone_trial(input int ch, input int p, input int v);
    int per, ones, rv, rv3;
    longint ex64;
    do_reset();
    rd(ch * 4 + 2, rv, rv3);
    check("reset_ctrl", rv, 0);
    wr(ch * 4 + 0, p & 255);
    wr(ch * 4 + 1, p >> 8);
    wr(ch * 4 + 3, v);
    wr(ch * 4 + 2, 8'h80);
    meas_period(per);
    check("tone_period", near(per, 8 * (p + 1), 8), 8 * (p + 1));
    count_ones(80 * (p + 1), ones);
    ex64 = 40 * (p + 1) * v;
    check("tone_density",
          ((64 * ones - ex64) <= 128 && (ex64 - 64 * ones) <= 128) ? (ex64 + 32) / 64 : ones,
          (ex64 + 32) / 64);
  endtask

  initial begin
    int v, v3, w, ones, per, h;
    int m_lo[4], m_hi[4], m_ctrl[4], m_env[4];
    logic [39:0] got, exp_bits;
    logic [14:0] s;

    // Reset state
    do_reset();
    for (int a = 0; a < 16; a++) begin
      rd(a, v, v3);
      check($sformatf("reset_reg%0d", a), v, 0);
    end
    count_ones(1000, ones);
    check("reset_silent", ones, 0);

    // Square tone, fixed case then randomized channel/period/volume
    tone_trial(0, 49, 15);
    for (int t = 0; t < 3; t++)
      tone_trial($urandom_range(0, 3), $urandom_range(8, 24), $urandom_range(10, 15));

    // Atomic period commit on ch1
    do_reset();
    wr(4, 8'h00); wr(5, 8'h01); wr(7, 8'h0F); wr(6, 8'h80);
    meas_period(per);
    check("atomic_p100", near(per, 8 * 257, 8), 8 * 257);
    wr(4, 8'h10);
    rd(4, v, v3); check("atomic_lo_rd", v, 8'h10);
    rd(5, v, v3); check("atomic_hi_rd", v, 8'h01);
    meas_period(per);
    check("atomic_lo_only", near(per, 8 * 257, 8), 8 * 257);
    wr(5, 8'h00);
    rd(5, v, v3); check("atomic_hi_rd0", v, 0);
    next_rise(per);
    meas_period(per);
    check("atomic_new_p", near(per, 8 * 17, 8), 8 * 17);

    // Noise on ch3: silent at period 0, then LFSR bits against the model
    do_reset();
    wr(15, 8'h0F); wr(14, 8'hC0);
    count_ones(200, ones);
    check("noise_p0_silent", ones, 0);
    wr(12, 8'h01);
    align(0);
    wr(13, 8'h00);
    h = since_rst;
    wait_to(h + 4);  // first tick at h+3, output visible two clk later
    s = 15'h0001;
    for (int k = 0; k < 40; k++) begin
      count_ones(8, ones);
      got[k] = (ones > 0);
      s = ref_lfsr(s);
      exp_bits[k] = s[0];
    end
    check("noise_bits_lo", longint'(got[19:0]), longint'(exp_bits[19:0]));
    check("noise_bits_hi", longint'(got[39:20]), longint'(exp_bits[39:20]));

    // Decay, write-vs-decay collision, one-shot stop on ch2
    do_reset();
    align(3);
    wr(11, 8'h1F);
    w = since_rst;
    wr(10, 8'hA0);
    wait_to(w + 16383); rd(11, v, v3); check("decay_before", v, 8'h1F);
    wait_to(w + 16384); rd(11, v, v3); check("decay_step1", v, 8'h1E);
    rd(10, v, v3); check("decay_ctrl_on", v, 8'hA0);
    wait_to(w + 32767);
    wr(11, 8'h11);
    rd(11, v, v3); check("env_write_wins", v, 8'h11);
    wait_to(w + 49151); rd(11, v, v3); check("decay_restart", v, 8'h11);
    wait_to(w + 49152); rd(11, v, v3); check("decay_to_zero", v, 8'h10);
    wait_to(w + 49155); rd(10, v, v3); check("oneshot_clear", v, 8'h20);

    // Randomized register traffic against a register-file model; NCH=3 copy ignores ch3
    do_reset();
    for (int c = 0; c < 4; c++) begin m_lo[c] = 0; m_hi[c] = 0; m_ctrl[c] = 0; m_env[c] = 0; end
    for (int n = 0; n < 40; n++) begin
      int a, d, c;
      a = $urandom_range(0, 15);
      d = $urandom_range(0, 255);
      wr(a, d);
      @(negedge clk);
      c = a / 4;
      case (a % 4)
        0: m_lo[c] = d;
        1: m_hi[c] = d;
        2: m_ctrl[c] = d & 8'hE0;
        default: m_env[c] = d;
      endcase
      if ((m_ctrl[c] & 8'hA0) == 8'hA0 && (m_env[c] % 16) == 0) m_ctrl[c] = m_ctrl[c] & 8'h60;
    end
    for (int a = 0; a < 16; a++) begin
      int e;
      case (a % 4)
        0: e = m_lo[a / 4];
        1: e = m_hi[a / 4];
        2: e = m_ctrl[a / 4];
        default: e = m_env[a / 4];
      endcase
      rd(a, v, v3);
      check($sformatf("rand_rd%0d", a), v, e);
      check($sformatf("rand_rd3_%0d", a), v3, (a >= 12) ? 0 : e);
    end
    addr = AW'($urandom_range(0, 11)); re = 1'b0;
    #1;
    check("re0_data", int'(data_out), 0);
    check("re0_data3", int'(data_out3), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sound_gen_io.md
# sound_gen_io

Parametrised multi-channel sound generator peripheral on the AVR 8-bit I/O port bus. It is the successor to the fixed four-register SN76477 wrapper. It provides NCH independent channels, each with a 16-bit tone/noise period, an 8-bit volume-with-decay envelope, and a digital mixer. The mix drives a first-order sigma-delta 1-bit output, so no external sound chip is needed. It sits on the I/O bus beside the other `_io` peripherals, and `signal_out` goes straight to the audio pin.

## Interface
- `NCH`, 4: number of channels, 1..8.
- `PRESCALE`, 4: clk cycles per generator tick (100 MHz / 4 = 25 MHz tick).
- `ADDR_W`, clog2(NCH)+2: register address width.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  reset, synchronous, active-low. All state is cleared on the clk edge where `reset`==0.
- `addr`  in  ADDR_W  register address: `addr[ADDR_W-1:2]` = channel, `addr[1:0]` = register.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data, combinational; 0 when `re`==0.
- `re`  in  1  read enable.
- `we`  in  1  write enable, one clk per write.
- `signal_out`  out  1  sigma-delta audio bit stream; reset value 0.

## Operation
Per-channel registers (all reset to 0x00):
- 0 `FREQ_LO`: staging byte for period[7:0].
- 1 `FREQ_HI`: writing it commits `{data_in, FREQ_LO}` atomically to the active 16-bit period. Reading it returns the committed period[15:8].
- 2 `CTRL`: [7] enable, [6] mode (0 square, 1 noise), [5] one-shot, [4:0] reserved (read 0).
- 3 `ENV`: [7:4] decay rate R, [3:0] volume V. A write loads the live volume with V. A read returns {R, live volume}.

Behaviour:
- Tick: a free-running prescaler asserts `tick` for one clk every PRESCALE clks.
- Period counter (16 bit) decrements on tick. At 0 it reloads the committed period and toggles the channel phase.
  - Square output = phase, so f = tick_rate / (2·(period+1)).
  - Noise: each phase toggle steps a per-channel 15-bit Galois LFSR (taps x^15+x^14+1, seed 0x0001 at reset, reseeded if it reaches 0); output = LFSR[0].
- Period 0: the channel is silent (output 0) and its counter holds at 0.
- Disabled channel (enable=0): output 0; counter and LFSR hold.
- Envelope:
  - R=0: live volume is constant.
  - R>0: a 16-bit decay counter, clocked on tick, decrements the live volume by 1 every R·4096 ticks, saturating at 0.
  - If one-shot=1 and the live volume reaches 0, enable is cleared by hardware.
- Mixer: amplitude_i = output_i ? live_vol_i : 0. sum = Σ amplitude_i, width 4+clog2(NCH), unsigned, no overflow possible.
- Sigma-delta: accumulator `acc` has width SUM_W+1. Every clk, `acc <= {1'b0, acc[SUM_W-1:0]} + sum` and `signal_out <= acc carry`. Output density = sum / 2^SUM_W.
- Addresses whose channel index is ≥ NCH: writes are ignored, reads return 0.

## Timing
- Register writes take effect on the clk edge where `we`=1. The new period is used at the next counter reload, never mid-count, so pitch changes are glitch-free.
- A `CTRL` write with enable 0→1 reloads the period counter and clears phase on the same edge.
- When an `ENV` write and a decay step fall in the same clk, the write wins and the decay counter restarts.
- When a one-shot auto-clear and a `CTRL` write fall in the same clk, the CPU write wins.
- `data_out` is valid in the same cycle as `re`/`addr`. Reads have no side effects.
- Reset mid-note: on the next edge all registers, counters, and `acc` are 0, LFSRs are 0x0001, and `signal_out`=0.
- Latency from the period counter reaching 0 to a change in `signal_out` density: 2 clk (mixer register plus accumulator).

## Structure
- Package `sound_gen_pkg`: register offsets (`REG_FREQ_LO`..`REG_ENV`), CTRL bit positions, LFSR seed and taps, and the decay step constant 4096.
- Sub-module `sound_channel`: one instance per channel via generate. It contains the period counter, phase, LFSR, envelope, and one-shot logic, and outputs a 4-bit amplitude.
- The top level contains the prescaler, address decode and readback mux, the mixer adder tree, and the sigma-delta modulator.

## Test plan
- Reset: hold `reset`=0 for 3 clk → every register reads 0x00, `signal_out`=0 for 1000 clk.
- Square tone: ch0 period=0x0031 (49), ENV=0x0F, CTRL=0x80 → channel phase period is 400 clk (250 kHz tone at 100 MHz). `signal_out` ones-density is 0.5·15/64 ±1% over 10 periods with NCH=4.
- Atomic commit: ch1 running with period 0x0100; write only FREQ_LO=0x10 → pitch unchanged. Then write FREQ_HI=0x00 → new half-period of 0x11 ticks starts at the next reload.
- Decay and one-shot: ch2 ENV=0x1F, CTRL=0xA0 → live volume reads 0xE after 4096 ticks and reaches 0 after 15·4096 ticks. CTRL then reads 0x20 (enable cleared).
- Noise: ch3 CTRL=0xC0, period=0 → output stays 0. Set period=1 → LFSR sequence matches the model starting 0x0001, with 32767 distinct states before repeating.
- Bus edge cases: with NCH=3, a write to channel 3 is ignored and a read returns 0. `re`=0 gives `data_out`=0. A write and a decay step in the same clk → the written volume is held.
